// File: rtl/sd_sector_arbiter_if.sv
// sd_sector_arbiter_if: bundle of per-unit request lines and the shared hps_io sector channel.
interface sd_sector_arbiter_if #(
    parameter int NDRV = 4
);
    logic [NDRV-1:0]      req_rd;
    logic [NDRV-1:0]      req_wr;
    logic [32*NDRV-1:0]   req_lba;
    logic [8*NDRV-1:0]    req_buff_din;
    logic [NDRV-1:0]      req_busy;
    logic [NDRV-1:0]      req_done;
    logic [NDRV-1:0]      req_err;
    logic [NDRV-1:0]      req_buff_wr;
    logic [31:0]          sd_lba;
    logic [NDRV-1:0]      sd_rd;
    logic [NDRV-1:0]      sd_wr;
    logic [NDRV-1:0]      sd_ack;
    logic                 sd_buff_wr;
    logic [7:0]           sd_buff_din;

    modport master (
        input  req_rd, req_wr, req_lba, req_buff_din, sd_ack, sd_buff_wr,
        output req_busy, req_done, req_err, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        output req_rd, req_wr, req_lba, req_buff_din, sd_ack, sd_buff_wr,
        input  req_busy, req_done, req_err, req_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
    );
endinterface

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: round-robin sharing of the hps_io sector channel between up to four disk units.
module sd_sector_arbiter #(
    parameter int          NDRV      = 4,
    parameter logic [23:0] TO_CYCLES = 24'd4_000_000
) (
    input  logic                clk_sys,
    input  logic                reset,
    sd_sector_arbiter_if.master bus
);
    localparam int GW = (NDRV > 1) ? $clog2(NDRV) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, XFER, DONE, ERR} state_t;

    state_t          state, next_state;
    logic [GW-1:0]   g, last, pick;
    logic            pick_ok, dir_wr, sel_ack, sel_req, to_hit;
    logic            strobe_d, done_d, err_d;
    logic [23:0]     cnt;
    logic [NDRV-1:0] pend, oh_g, oh_pick;
    logic [31:0]     lba_arr [NDRV];
    logic [7:0]      din_arr [NDRV];

    function automatic logic [GW-1:0] wrap(input int v);
        return GW'(v % NDRV);
    endfunction

    for (genvar i = 0; i < NDRV; i++) begin : g_unpack
        assign lba_arr[i] = bus.req_lba[32*i +: 32];
        assign din_arr[i] = bus.req_buff_din[8*i +: 8];
    end

    assign pend    = bus.req_rd | bus.req_wr;
    assign oh_g    = NDRV'(1) << g;
    assign oh_pick = NDRV'(1) << pick;
    assign sel_ack = bus.sd_ack[g];
    assign sel_req = pend[g];
    assign to_hit  = cnt == TO_CYCLES - 24'd1;

    // Scan farthest-first so the unit nearest after last is the final override.
    always_comb begin
        pick = last;
        pick_ok = 1'b0;
        for (int k = NDRV; k >= 1; k--) begin
            if (pend[wrap(int'(last) + k)]) begin
                pick = wrap(int'(last) + k);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end

    // Ack beats both timeout and abort in ISSUE; ack falling beats timeout in XFER.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = pick_ok ? ISSUE : IDLE;
            ISSUE:   next_state = sel_ack ? XFER : to_hit ? ERR : sel_req ? ISSUE : IDLE;
            XFER:    next_state = !sel_ack ? DONE : to_hit ? ERR : XFER;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        strobe_d = state == ISSUE && next_state == ISSUE;
        done_d   = state == DONE;
        err_d    = state == ERR;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            g            <= '0;
            last         <= GW'(NDRV - 1);
            dir_wr       <= 1'b0;
            cnt          <= '0;
            bus.sd_lba   <= '0;
            bus.req_busy <= '0;
            bus.sd_rd    <= '0;
            bus.sd_wr    <= '0;
            bus.req_done <= '0;
            bus.req_err  <= '0;
        end else begin
            if (state == IDLE && pick_ok) begin
                g          <= pick;
                dir_wr     <= bus.req_wr[pick];
                bus.sd_lba <= lba_arr[pick];
                cnt        <= '0;
            end else if ((state == ISSUE || state == XFER) && cnt != '1) begin
                cnt <= cnt + 24'd1;
            end
            if (done_d || err_d) last <= g;
            bus.req_busy <= next_state == IDLE ? '0 : state == IDLE ? oh_pick : bus.req_busy;
            bus.sd_rd    <= (strobe_d && !dir_wr) ? oh_g : '0;
            bus.sd_wr    <= (strobe_d && dir_wr) ? oh_g : '0;
            bus.req_done <= done_d ? oh_g : '0;
            bus.req_err  <= err_d ? oh_g : '0;
        end
    end

    assign bus.sd_buff_din = |bus.req_busy ? din_arr[g] : 8'd0;
    assign bus.req_buff_wr = bus.req_busy & {NDRV{bus.sd_buff_wr}};
endmodule
